// File: rtl/ub_pkg.sv
// Shared types and defaults for the affine-addressed unified buffer.
// Optional write-forwarding is selected with the UB_WR_FORWARD_EN macro in ub_affine_sram.
package ub_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_NDIM   = 3;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        UB_IDLE = 2'd0,
        UB_RUN  = 2'd1,
        UB_DONE = 2'd2
    } ub_state_t;

    // A zero extent still means one pass through that loop level.
    function automatic logic [31:0] ext_nz(input logic [31:0] ext);
        return (ext == 32'd0) ? 32'd1 : ext;
    endfunction

endpackage

// File: rtl/ub_affine_agen.sv
// Affine loop-nest address generator: idx[0] is innermost and carries outward.
// Fires once the shared cycle counter reaches start_cyc, then issues one access per cycle.
module ub_affine_agen
    import ub_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NDIM   = DEF_NDIM,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic [CNT_W-1:0]       count,
    input  logic [CNT_W-1:0]       start_cyc,
    input  logic [NDIM*CNT_W-1:0]  extent,
    input  logic [NDIM*ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0]      offset,
    output logic                   active,
    output logic                   last,
    output logic                   exhausted,
    output logic [ADDR_W-1:0]      addr
);

    logic [CNT_W-1:0]  idx_reg  [NDIM];
    logic [CNT_W-1:0]  idx_next [NDIM];
    logic [ADDR_W-1:0] term     [NDIM];
    logic [NDIM-1:0]   at_max;
    logic              started_reg;
    logic              exhausted_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NDIM; gi++) begin : g_dim
            logic [31:0] ext_w;
            assign ext_w      = ext_nz(32'(extent[gi*CNT_W +: CNT_W]));
            assign at_max[gi] = (32'(idx_reg[gi]) == ext_w - 32'd1);
            // Only the low ADDR_W bits of each product survive the modulo.
            assign term[gi]   = ADDR_W'(idx_reg[gi]) * stride[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    always_comb begin : p_idx_next
        logic carry;
        carry = 1'b1;
        for (int d = 0; d < NDIM; d++) begin
            idx_next[d] = idx_reg[d];
            if (carry) begin
                idx_next[d] = at_max[d] ? '0 : idx_reg[d] + CNT_W'(1);
            end
            carry = carry & at_max[d];
        end
    end

    always_comb begin
        addr = offset;
        for (int d = 0; d < NDIM; d++) begin
            addr = addr + term[d];
        end
    end

    assign active    = en && !exhausted_reg && (started_reg || (count == start_cyc));
    assign last      = active && (&at_max);
    assign exhausted = exhausted_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            started_reg   <= 1'b0;
            exhausted_reg <= 1'b0;
            for (int d = 0; d < NDIM; d++) begin
                idx_reg[d] <= '0;
            end
        end else if (active) begin
            started_reg <= 1'b1;
            if (&at_max) begin
                exhausted_reg <= 1'b1;
            end
            for (int d = 0; d < NDIM; d++) begin
                idx_reg[d] <= idx_next[d];
            end
        end
    end

endmodule

// File: rtl/ub_affine_sram.sv
// Unified buffer: one SRAM fed by an affine write generator and drained by an affine read generator.
// Define UB_WR_FORWARD_EN to forward data_in to a same-cycle, same-address read (default: read-first).
module ub_affine_sram
    import ub_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NDIM   = DEF_NDIM,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   start,
    input  logic                   cfg_en,
    input  logic [NDIM*CNT_W-1:0]  cfg_wr_extent,
    input  logic [NDIM*CNT_W-1:0]  cfg_rd_extent,
    input  logic [NDIM*ADDR_W-1:0] cfg_wr_stride,
    input  logic [NDIM*ADDR_W-1:0] cfg_rd_stride,
    input  logic [ADDR_W-1:0]      cfg_wr_offset,
    input  logic [ADDR_W-1:0]      cfg_rd_offset,
    input  logic [CNT_W-1:0]       cfg_wr_start,
    input  logic [CNT_W-1:0]       cfg_rd_start,
    input  logic [DATA_W-1:0]      data_in,
    output logic                   wr_active,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid_out,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'(UB_IDLE);
    localparam logic [1:0] ST_RUN  = 2'(UB_RUN);
    localparam logic [1:0] ST_DONE = 2'(UB_DONE);

    logic [1:0]             state_reg, state_next;
    logic [CNT_W-1:0]       count_reg;
    logic [NDIM*CNT_W-1:0]  wr_ext_reg, rd_ext_reg;
    logic [NDIM*ADDR_W-1:0] wr_str_reg, rd_str_reg;
    logic [ADDR_W-1:0]      wr_off_reg, rd_off_reg;
    logic [CNT_W-1:0]       wr_start_reg, rd_start_reg;
    logic [DATA_W-1:0]      data_out_reg;
    logic                   valid_out_reg;

    logic [DATA_W-1:0]      mem [DEPTH];

    logic                   in_idle, in_run, gen_en, gen_clear;
    logic                   wr_act, wr_last, wr_exh;
    logic                   rd_act, rd_exh, rd_last_unused;
    logic [ADDR_W-1:0]      wr_addr, rd_addr;

    assign in_idle   = (state_reg == ST_IDLE);
    assign in_run    = (state_reg == ST_RUN);
    assign gen_en    = in_run && !flush;
    assign gen_clear = (in_idle && start) || (in_run && flush);

    ub_affine_agen #(.ADDR_W(ADDR_W), .NDIM(NDIM), .CNT_W(CNT_W)) u_wr_agen (
        .clk       (clk),
        .rst       (rst),
        .clear     (gen_clear),
        .en        (gen_en),
        .count     (count_reg),
        .start_cyc (wr_start_reg),
        .extent    (wr_ext_reg),
        .stride    (wr_str_reg),
        .offset    (wr_off_reg),
        .active    (wr_act),
        .last      (wr_last),
        .exhausted (wr_exh),
        .addr      (wr_addr)
    );

    ub_affine_agen #(.ADDR_W(ADDR_W), .NDIM(NDIM), .CNT_W(CNT_W)) u_rd_agen (
        .clk       (clk),
        .rst       (rst),
        .clear     (gen_clear),
        .en        (gen_en),
        .count     (count_reg),
        .start_cyc (rd_start_reg),
        .extent    (rd_ext_reg),
        .stride    (rd_str_reg),
        .offset    (rd_off_reg),
        .active    (rd_act),
        .last      (rd_last_unused),
        .exhausted (rd_exh),
        .addr      (rd_addr)
    );

    // The write side may finish in the current cycle; the read side must have
    // issued its last access earlier so that its data is already on data_out.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (!flush && (wr_exh || wr_last) && rd_exh) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (in_idle && start) begin
                count_reg <= '0;
            end else if (in_run) begin
                if (flush) begin
                    count_reg <= '0;
                end else if (count_reg != {CNT_W{1'b1}}) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ext_reg   <= '0;
            rd_ext_reg   <= '0;
            wr_str_reg   <= '0;
            rd_str_reg   <= '0;
            wr_off_reg   <= '0;
            rd_off_reg   <= '0;
            wr_start_reg <= '0;
            rd_start_reg <= '0;
        end else if (in_idle && cfg_en) begin
            wr_ext_reg   <= cfg_wr_extent;
            rd_ext_reg   <= cfg_rd_extent;
            wr_str_reg   <= cfg_wr_stride;
            rd_str_reg   <= cfg_rd_stride;
            wr_off_reg   <= cfg_wr_offset;
            rd_off_reg   <= cfg_rd_offset;
            wr_start_reg <= cfg_wr_start;
            rd_start_reg <= cfg_rd_start;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_act) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= rd_act;
            if (rd_act) begin
`ifdef UB_WR_FORWARD_EN
                data_out_reg <= (wr_act && (wr_addr == rd_addr)) ? data_in : mem[rd_addr];
`else
                data_out_reg <= mem[rd_addr];
`endif
            end
        end
    end

    assign wr_active = wr_act;
    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign busy      = in_run;
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ub_affine_sram.sv
// Scoreboard bench for ub_affine_sram: a reference loop-nest model predicts every read and the done cycle.
// Build with +define+UB_WR_FORWARD_EN to check the write-forward variant.
module tb_ub_affine_sram;

    logic        clk = 1'b0;
    logic        rst, flush, start, cfg_en;
    logic [47:0] cfg_wr_extent, cfg_rd_extent;
    logic [26:0] cfg_wr_stride, cfg_rd_stride;
    logic [8:0]  cfg_wr_offset, cfg_rd_offset;
    logic [15:0] cfg_wr_start, cfg_rd_start;
    logic [15:0] data_in, data_out;
    logic        wr_active, valid_out, busy, done;

    always #5 clk = ~clk;

    ub_affine_sram dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .start         (start),
        .cfg_en        (cfg_en),
        .cfg_wr_extent (cfg_wr_extent),
        .cfg_rd_extent (cfg_rd_extent),
        .cfg_wr_stride (cfg_wr_stride),
        .cfg_rd_stride (cfg_rd_stride),
        .cfg_wr_offset (cfg_wr_offset),
        .cfg_rd_offset (cfg_rd_offset),
        .cfg_wr_start  (cfg_wr_start),
        .cfg_rd_start  (cfg_rd_start),
        .data_in       (data_in),
        .wr_active     (wr_active),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        sb [$];
    int          wa [$];
    int          ra [$];
    logic [15:0] mem_m [512];
    int          n_cmp = 0;
    int          n_err = 0;

    int w_ext [3], w_str [3], w_off, w_start, w_base;
    int r_ext [3], r_str [3], r_off, r_start;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input int e);
        return (e == 0) ? 1 : e;
    endfunction

    task automatic build_addrs();
        wa.delete();
        ra.delete();
        for (int i2 = 0; i2 < eff(w_ext[2]); i2++)
            for (int i1 = 0; i1 < eff(w_ext[1]); i1++)
                for (int i0 = 0; i0 < eff(w_ext[0]); i0++)
                    wa.push_back((w_off + i0 * w_str[0] + i1 * w_str[1] + i2 * w_str[2]) % 512);
        for (int i2 = 0; i2 < eff(r_ext[2]); i2++)
            for (int i1 = 0; i1 < eff(r_ext[1]); i1++)
                for (int i0 = 0; i0 < eff(r_ext[0]); i0++)
                    ra.push_back((r_off + i0 * r_str[0] + i1 * r_str[1] + i2 * r_str[2]) % 512);
    endtask

    task automatic apply_cfg();
        cfg_wr_extent = {16'(w_ext[2]), 16'(w_ext[1]), 16'(w_ext[0])};
        cfg_rd_extent = {16'(r_ext[2]), 16'(r_ext[1]), 16'(r_ext[0])};
        cfg_wr_stride = {9'(w_str[2]), 9'(w_str[1]), 9'(w_str[0])};
        cfg_rd_stride = {9'(r_str[2]), 9'(r_str[1]), 9'(r_str[0])};
        cfg_wr_offset = 9'(w_off);
        cfg_rd_offset = 9'(r_off);
        cfg_wr_start  = 16'(w_start);
        cfg_rd_start  = 16'(r_start);
        cfg_en = 1'b1;
        @(posedge clk); #1;
        cfg_en = 1'b0;
    endtask

    // Counter value seen by the generators in bench cycle c (0 = first RUN cycle).
    function automatic int cnt_at(input int c, input int flush_at);
        return (flush_at >= 0 && c > flush_at) ? c - flush_at - 1 : c;
    endfunction

    task automatic run_sched(input string name, input int flush_at, input bit glitch, input bit start_flush);
        int last_wr = -1;
        int last_rd = -1;
        int done_c;
        build_addrs();
        for (int c = 0; c < 300; c++) begin
            int          k;
            bit          act, w_on, r_on;
            logic [15:0] wd, v;
            int          waddr;
            k     = cnt_at(c, flush_at);
            act   = (c != flush_at);
            w_on  = act && k >= w_start && k < w_start + wa.size();
            r_on  = act && k >= r_start && k < r_start + ra.size();
            wd    = 16'(w_base + k - w_start);
            waddr = w_on ? wa[k - w_start] : -1;
            if (r_on) begin
                v = mem_m[ra[k - r_start]];
`ifdef UB_WR_FORWARD_EN
                if (waddr == ra[k - r_start]) v = wd;
`endif
                sb.push_back('{cyc: c + 1, data: v});
                last_rd = c;
            end
            if (w_on) begin
                mem_m[waddr] = wd;
                last_wr = c;
            end
        end
        done_c = (last_wr + 1 > last_rd + 2) ? last_wr + 1 : last_rd + 2;

        apply_cfg();
        start = 1'b1;
        flush = start_flush;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        for (int c = 0; c <= done_c + 1; c++) begin
            int k;
            bit w_on, exp_v;
            k    = cnt_at(c, flush_at);
            w_on = (c != flush_at) && k >= w_start && k < w_start + wa.size();
            data_in = w_on ? 16'(w_base + k - w_start) : 16'($urandom);
            flush   = (c == flush_at);
            if (glitch && c == 1) begin
                cfg_en        = 1'b1;
                start         = 1'b1;
                cfg_rd_offset = ~cfg_rd_offset;
                cfg_wr_offset = cfg_wr_offset + 9'd3;
            end else begin
                cfg_en = 1'b0;
                start  = 1'b0;
            end
            @(negedge clk);
            exp_v = (sb.size() > 0) && (sb[0].cyc == c);
            chk({name, " valid_out"}, 32'(valid_out), 32'(exp_v));
            if (exp_v) begin
                $display("%s: cycle %0d data_out=%0d expected=%0d", name, c, data_out, sb[0].data);
                chk({name, " data_out"}, 32'(data_out), 32'(sb[0].data));
                void'(sb.pop_front());
            end
            if (c != flush_at) chk({name, " wr_active"}, 32'(wr_active), 32'(w_on));
            chk({name, " busy"}, 32'(busy), 32'(c < done_c));
            chk({name, " done"}, 32'(done), 32'(c == done_c));
            @(posedge clk); #1;
        end
        cfg_en = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        chk({name, " reads outstanding"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic set_wr(input int e0, e1, e2, s0, s1, s2, off, st, base);
        w_ext = '{e0, e1, e2};
        w_str = '{s0, s1, s2};
        w_off = off; w_start = st; w_base = base;
    endtask

    task automatic set_rd(input int e0, e1, e2, s0, s1, s2, off, st);
        r_ext = '{e0, e1, e2};
        r_str = '{s0, s1, s2};
        r_off = off; r_start = st;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0; cfg_en = 1'b0; data_in = '0;
        cfg_wr_extent = '0; cfg_rd_extent = '0; cfg_wr_stride = '0; cfg_rd_stride = '0;
        cfg_wr_offset = '0; cfg_rd_offset = '0; cfg_wr_start = '0; cfg_rd_start = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset wr_active", 32'(wr_active), 32'd0);
        chk("reset data_out", 32'(data_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Linear write then read-back, done on cycle 9.
        set_wr(4, 1, 1, 1, 0, 0, 0, 0, 10);
        set_rd(4, 1, 1, 1, 0, 0, 0, 4);
        run_sched("linear", -1, 1'b0, 1'b0);

        // Strided read (11, 13); cfg_en and start during RUN must not disturb it.
        set_wr(1, 1, 1, 0, 0, 0, 200, 0, 99);
        set_rd(2, 1, 1, 2, 0, 0, 1, 0);
        run_sched("stride2", -1, 1'b1, 1'b0);

        // Same-address write and read in one cycle; flush alongside start is ignored.
        set_wr(2, 1, 1, 0, 0, 0, 5, 0, 7);
        set_rd(1, 1, 1, 0, 0, 0, 5, 1);
        run_sched("collide", -1, 1'b0, 1'b1);

        // Address wraps past 511 for both generators.
        set_wr(4, 1, 1, 1, 0, 0, 510, 0, 20);
        set_rd(3, 1, 1, 1, 0, 0, 511, 4);
        run_sched("wrap", -1, 1'b0, 1'b0);

        // Two-level nest with carry, read transposed, zero extent treated as one.
        set_wr(2, 2, 1, 1, 4, 0, 8, 0, 40);
        set_rd(2, 2, 0, 4, 1, 0, 8, 4);
        run_sched("nest2d", -1, 1'b0, 1'b0);

        // Flush in cycle 2 while reads are in flight: schedule replays from zero.
        set_wr(1, 1, 1, 0, 0, 0, 100, 0, 55);
        set_rd(4, 1, 1, 1, 0, 0, 0, 0);
        run_sched("flush", 2, 1'b0, 1'b0);

        // Reset in the middle of a run aborts it on the next edge.
        set_wr(4, 1, 1, 1, 0, 0, 0, 0, 10);
        set_rd(4, 1, 1, 1, 0, 0, 0, 1);
        apply_cfg();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("midrun busy before rst", 32'(busy), 32'd1);
        chk("midrun valid before rst", 32'(valid_out), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid_out", 32'(valid_out), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst wr_active", 32'(wr_active), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ub_affine_sram.md
UB_AFFINE_SRAM -- requirements
Module: ub_affine_sram

Interface
REQ-001 Param DATA_W, default 16, data word width.
REQ-002 Param ADDR_W, default 9, address width; memory depth 2**ADDR_W words.
REQ-003 Param NDIM, default 3, loop-nest dimensions per address generator.
REQ-004 Param CNT_W, default 16, width of extents, start times and cycle counter.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  restart current schedule.
REQ-008 start  in  1  begin schedule from IDLE.
REQ-009 cfg_en  in  1  latch all cfg_* inputs.
REQ-010 cfg_wr_extent / cfg_rd_extent  in  NDIM*CNT_W  per-dim loop counts, dim 0 innermost.
REQ-011 cfg_wr_stride / cfg_rd_stride  in  NDIM*ADDR_W  per-dim address strides.
REQ-012 cfg_wr_offset / cfg_rd_offset  in  ADDR_W  base address.
REQ-013 cfg_wr_start / cfg_rd_start  in  CNT_W  cycle at which generator begins.
REQ-014 data_in  in  DATA_W  write data, sampled when wr_active=1.
REQ-015 wr_active  out  1  data_in consumed this cycle.
REQ-016 data_out  out  DATA_W  read data.
REQ-017 valid_out  out  1  data_out valid.
REQ-018 busy  out  1  state is RUN.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when both generators exhausted and no read in flight; DONE->IDLE after exactly one cycle.
REQ-021 cfg_en honoured only in IDLE; ignored in RUN and DONE.
REQ-022 Cycle counter clears on entering RUN, increments each RUN cycle, saturates at 2**CNT_W-1.
REQ-023 Each generator becomes active when cycle counter == its start value and then issues one access per cycle until its extent product is consumed.
REQ-024 Generator address = (offset + sum of idx[d]*stride[d]) mod 2**ADDR_W; idx[0] increments per access; idx[d] wraps to 0 at extent[d]-1 and carries into idx[d+1].
REQ-025 Extent of 0 is treated as 1.
REQ-026 Write generator active: wr_active=1, data_in written at its address that cycle.
REQ-027 Read generator active: memory read issued; data_out/valid_out appear exactly 1 cycle later.
REQ-028 Same-address read and write in one cycle: data_out returns old contents (read-first) unless UB_WR_FORWARD_EN is defined.
REQ-029 flush in RUN: cycle counter, loop indices and in-flight read cleared; valid_out=0 next cycle; state stays RUN; memory contents retained.
REQ-030 flush in IDLE or DONE ignored; flush and start together in IDLE: start wins.
REQ-031 start ignored outside IDLE.
REQ-032 done=1 only in DONE, one cycle, the cycle after the final valid_out (or the final write if read finished earlier).

Reset
REQ-033 rst: state IDLE; data_out=0, valid_out=0, wr_active=0, busy=0, done=0; counters, indices and configuration registers 0.
REQ-034 rst mid-RUN aborts schedule next edge; memory contents undefined thereafter.

Configuration
REQ-035 Macro UB_WR_FORWARD_EN defined: same-cycle same-address read returns data_in (write-forward); undefined: returns previous stored word.

Structure
REQ-036 Package ub_pkg holds state enum type, default parameter constants, and helper function for extent-0-as-1.
REQ-037 Sub-module ub_affine_agen (loop nest + address + active/exhausted flags) instantiated twice, write and read.

Verification
REQ-038 Write extents {4,1,1} stride {1,0,0} offset 0 start 0, data 10..13; read same pattern start 4 -> valid_out cycles 5-8 with data 10,11,12,13; done pulses cycle 9.
REQ-039 Read stride {2,0,0} extent {2,1,1} offset 1 over memory 10..13 -> data_out 11 then 13.
REQ-040 Write and read both addr 5 same cycle, stored 7, data_in 9 -> data_out 7 without macro, 9 with UB_WR_FORWARD_EN.
REQ-041 Offset 510, stride 1, extent 4, ADDR_W=9 -> addresses 510,511,0,1.
REQ-042 flush asserted in cycle 2 of RUN -> valid_out 0 next cycle, schedule replays from cycle 0, busy stays 1.
REQ-043 rst asserted mid-RUN -> next cycle busy=0, valid_out=0, done=0; cfg_en during RUN has no effect on addresses.
